debounce_sync: RTL and testbench
================================

# debounce_sync

Input-conditioning stage that sits directly upstream of the registered flop stage. It takes a raw asynchronous level, such as a push-button or external strobe, and synchronises it into `clk`. It then debounces the level with a stability counter and presents a clean level, `dout`, which is wired to the flop's `din`. It also emits single-cycle rise and fall pulses for control logic that needs edges rather than levels.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops; legal range 2..4.
- `STABLE_CNT`, default 50000: number of consecutive synchronised samples at the new value required before `dout` changes; legal range 2..2^20-1. The counter width is derived internally as clog2(`STABLE_CNT`).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted); release is assumed synchronous to `clk` upstream.
- `din_async`  in  1  raw, unsynchronised input level.
- `dout`  out  1  debounced level; feeds the downstream flop `din`.
- `rise`  out  1  one-cycle pulse, high in the cycle `dout` goes 0->1.
- `fall`  out  1  one-cycle pulse, high in the cycle `dout` goes 1->0.
- `busy`  out  1  high while a candidate transition is being qualified (WAIT states).

## Operation
- **Synchroniser:**
  - `din_async` passes through a `SYNC_STAGES`-deep flop chain.
  - `s` is the last stage of the chain; no other logic samples `din_async`.
- **FSM states:** `STABLE_LO`, `WAIT_HI`, `STABLE_HI`, `WAIT_LO`. The counter `cnt` is shared.
- **`STABLE_LO`:**
  - `s`=1: go to `WAIT_HI` with `cnt`<=1.
  - Otherwise: stay, with `cnt`<=0.
- **`WAIT_HI`:**
  - `s`=0: return to `STABLE_LO` with `cnt`<=0. The glitch is rejected and produces no pulse.
  - `s`=1 and `cnt`==`STABLE_CNT`-1: go to `STABLE_HI`, `dout`<=1, `rise`<=1, `cnt`<=0.
  - `s`=1 otherwise: `cnt`<=`cnt`+1.
- **`STABLE_HI` / `WAIT_LO`:** mirror images of the above, with `fall` as the pulse.
- **Outputs:**
  - `dout` is registered and equals 1 exactly in `STABLE_HI` and `WAIT_LO`.
  - `rise` and `fall` are registered and are never high simultaneously.
  - `busy` = state is `WAIT_HI` or `WAIT_LO`.
- **Counter:** never exceeds `STABLE_CNT`-1 and never wraps.
- **Bounce restart:** any bounce during WAIT restarts qualification from zero on the next change toward the new value.
- **Reset** (`reset`=0, asynchronous, takes effect immediately, including mid-WAIT):
  - sync chain all 0, state `STABLE_LO`, `cnt`=0;
  - `dout`=0, `rise`=0, `fall`=0, `busy`=0.
- **After reset release with `din_async` held high:** `dout` rises through a normal qualification, and `rise` pulses once.

## Timing
- **Latency:** count the first rising edge that samples a new stable `din_async` as edge 1. `dout` changes, and `rise`/`fall` assert, on edge `SYNC_STAGES`+`STABLE_CNT`.
- **Pulse width:** `rise`/`fall` are high for exactly one cycle and deassert on the following edge.
- **Glitch rejection:** a synchronised pulse shorter than `STABLE_CNT` cycles never changes `dout`.
- **Minimum toggle spacing:** at least `STABLE_CNT` cycles between consecutive `dout` changes.
- **Reset exit:** `busy` can first assert at edge `SYNC_STAGES`+1 after `reset` deasserts, and only if `din_async` is high.

## Test plan
Unless noted, `SYNC_STAGES`=2, `STABLE_CNT`=4, and `din_async` changes away from the clock edge.
- **Clean rise:** `din_async` 0->1 and held → `busy`=1 from edge 3; `dout`=1 and `rise`=1 at edge 6 only; `rise`=0 at edge 7; `fall` stays 0.
- **Glitch:** `din_async` high for 3 cycles, then low → `busy` pulses high; `dout`, `rise` and `fall` stay 0 throughout.
- **Bounce:** pattern 1,1,0,1,1,1,1 then held → qualification restarts after the 0; `dout` rises 4 samples after the last 1-run begins; exactly one `rise`.
- **Clean fall:** from `dout`=1, `din_async` 1->0 and held → `dout`=0 and `fall`=1 at edge 6; exactly one `fall` pulse.
- **Reset mid-WAIT:** assert `reset`=0 while `busy`=1 (`cnt`=2) → immediately `dout`=0, `busy`=0, no pulse. Release with `din_async` high → full 6-edge qualification, then one `rise`.
- **Parameter sweep:** `SYNC_STAGES`=3, `STABLE_CNT`=2 → `dout` change at edge 5 for a clean step; a 1-cycle glitch is rejected.

Source files
------------

// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : debounce_sync
// Brief    : Synchronises a raw level into clk, qualifies it with a stability
//            counter and emits a clean level plus single-cycle edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din_async,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int              CNT_W      = $clog2(STABLE_CNT);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] C_STABLE_LO = 2'd0;
  localparam logic [1:0] C_WAIT_HI   = 2'd1;
  localparam logic [1:0] C_STABLE_HI = 2'd2;
  localparam logic [1:0] C_WAIT_LO   = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  // Bit 0 takes the raw input; the last stage is the only sampled value.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din_async};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= C_STABLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      C_STABLE_LO: begin
        if (s) begin
          state_d = C_WAIT_HI;
          cnt_d   = C_CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      C_WAIT_HI: begin
        if (!s) begin
          state_d = C_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = C_STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + C_CNT_ONE;
        end
      end
      C_STABLE_HI: begin
        if (!s) begin
          state_d = C_WAIT_LO;
          cnt_d   = C_CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      C_WAIT_LO: begin
        if (s) begin
          state_d = C_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = C_STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + C_CNT_ONE;
        end
      end
      default: begin
        state_d = C_STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulses fire only on a completed qualification, never on a rejected glitch.
  always_comb begin
    dout_d = (state_d == C_STABLE_HI) || (state_d == C_WAIT_LO);
    rise_d = (state_q == C_WAIT_HI) && (state_d == C_STABLE_HI);
    fall_d = (state_q == C_WAIT_LO) && (state_d == C_STABLE_LO);
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == C_WAIT_HI) || (state_q == C_WAIT_LO);

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_sync
// Brief    : Self-checking bench for debounce_sync (2/4 and 3/2 configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, rst_n1, din0, din1;
  logic dout0, rise0, fall0, busy0;
  logic dout1, rise1, fall1, busy1;

  debounce_sync #(.SYNC_STAGES(2), .STABLE_CNT(4)) u_dut0 (
    .clk(clk), .reset(rst_n0), .din_async(din0),
    .dout(dout0), .rise(rise0), .fall(fall0), .busy(busy0)
  );

  debounce_sync #(.SYNC_STAGES(3), .STABLE_CNT(2)) u_dut1 (
    .clk(clk), .reset(rst_n1), .din_async(din1),
    .dout(dout1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  // Reference: s is the input as seen SYNC_STAGES edges ago; dout flips once
  // STABLE_CNT consecutive samples of s disagree with it.
  logic       m_dout [2];
  logic       m_rise [2];
  logic       m_fall [2];
  int         run    [2];
  logic [3:0] hist   [2];

  always @(posedge clk) begin
    logic rn, d, s;
    int   ss, sc;
    for (int i = 0; i < 2; i++) begin
      rn = (i == 0) ? rst_n0 : rst_n1;
      d  = (i == 0) ? din0 : din1;
      ss = (i == 0) ? 2 : 3;
      sc = (i == 0) ? 4 : 2;
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (!rn) begin
        hist[i]   = 4'b0;
        m_dout[i] = 1'b0;
        run[i]    = 0;
      end else begin
        s       = hist[i][ss-1];
        hist[i] = {hist[i][2:0], d};
        if (s != m_dout[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == sc) begin
            m_dout[i] = s;
            m_rise[i] = s;
            m_fall[i] = !s;
            run[i]    = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  end

  function automatic logic [3:0] exp0();
    return {m_dout[0], m_rise[0], m_fall[0], run[0] != 0};
  endfunction

  function automatic logic [3:0] exp1();
    return {m_dout[1], m_rise[1], m_fall[1], run[1] != 0};
  endfunction

  task automatic test_reset();
    rst_n0 = 1'b0; rst_n1 = 1'b0; din0 = 1'b0; din1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if ({dout0, rise0, fall0, busy0} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_dut0 cycle %0d: got %b expected 0000", k, {dout0, rise0, fall0, busy0});
      end
      checks++;
      if ({dout1, rise1, fall1, busy1} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_dut1 cycle %0d: got %b expected 0000", k, {dout1, rise1, fall1, busy1});
      end
    end
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clean_rise();
    din0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({dout0, rise0, fall0, busy0} !== {k >= 6, k == 6, 1'b0, k >= 3 && k < 6}) begin
        errors++;
        $display("FAIL clean_rise edge %0d: got %b expected %b", k, {dout0, rise0, fall0, busy0},
                 {k >= 6, k == 6, 1'b0, k >= 3 && k < 6});
      end
      checks++;
      if ({dout0, rise0, fall0, busy0} !== exp0()) begin
        errors++;
        $display("FAIL clean_rise_model edge %0d: got %b expected %b", k, {dout0, rise0, fall0, busy0}, exp0());
      end
    end
  endtask

  task automatic test_clean_fall();
    din0 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({dout0, rise0, fall0, busy0} !== {k < 6, 1'b0, k == 6, k >= 3 && k < 6}) begin
        errors++;
        $display("FAIL clean_fall edge %0d: got %b expected %b", k, {dout0, rise0, fall0, busy0},
                 {k < 6, 1'b0, k == 6, k >= 3 && k < 6});
      end
      checks++;
      if ({dout0, rise0, fall0, busy0} !== exp0()) begin
        errors++;
        $display("FAIL clean_fall_model edge %0d: got %b expected %b", k, {dout0, rise0, fall0, busy0}, exp0());
      end
    end
  endtask

  task automatic test_glitch();
    int busy_seen = 0;
    din0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy0 === 1'b1) busy_seen++;
      checks++;
      if ({dout0, rise0, fall0} !== 3'b000) begin
        errors++;
        $display("FAIL glitch edge %0d: dout/rise/fall got %b expected 000", k, {dout0, rise0, fall0});
      end
      checks++;
      if ({dout0, rise0, fall0, busy0} !== exp0()) begin
        errors++;
        $display("FAIL glitch_model edge %0d: got %b expected %b", k, {dout0, rise0, fall0, busy0}, exp0());
      end
      if (k == 3) din0 = 1'b0;
    end
    checks++;
    if (busy_seen != 3) begin
      errors++;
      $display("FAIL glitch_busy: busy cycles got %0d expected 3", busy_seen);
    end
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    int rises = 0;
    pat  = 7'b1111011;           // bit k-1 drives edge k: 1,1,0,1,1,1,1
    din0 = pat[0];
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rise0 === 1'b1) rises++;
      checks++;
      if ({dout0, rise0, fall0} !== {k >= 9, k == 9, 1'b0}) begin
        errors++;
        $display("FAIL bounce edge %0d: dout/rise/fall got %b expected %b", k, {dout0, rise0, fall0},
                 {k >= 9, k == 9, 1'b0});
      end
      checks++;
      if ({dout0, rise0, fall0, busy0} !== exp0()) begin
        errors++;
        $display("FAIL bounce_model edge %0d: got %b expected %b", k, {dout0, rise0, fall0, busy0}, exp0());
      end
      din0 = (k < 7) ? pat[k] : 1'b1;
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL bounce_rise_count: got %0d expected 1", rises);
    end
  endtask

  task automatic test_reset_mid_wait();
    int rises = 0;
    din0 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({dout0, busy0} !== 2'b11) begin
      errors++;
      $display("FAIL mid_wait_pre: dout/busy got %b expected 11", {dout0, busy0});
    end
    #2 rst_n0 = 1'b0;
    #1;
    checks++;
    if ({dout0, rise0, fall0, busy0} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_wait_async_reset: got %b expected 0000", {dout0, rise0, fall0, busy0});
    end
    din0 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n0 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rise0 === 1'b1) rises++;
      checks++;
      if ({dout0, rise0, fall0, busy0} !== {k >= 6, k == 6, 1'b0, k >= 3 && k < 6}) begin
        errors++;
        $display("FAIL reset_exit edge %0d: got %b expected %b", k, {dout0, rise0, fall0, busy0},
                 {k >= 6, k == 6, 1'b0, k >= 3 && k < 6});
      end
      checks++;
      if ({dout0, rise0, fall0, busy0} !== exp0()) begin
        errors++;
        $display("FAIL reset_exit_model edge %0d: got %b expected %b", k, {dout0, rise0, fall0, busy0}, exp0());
      end
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL reset_exit_rise_count: got %0d expected 1", rises);
    end
  endtask

  task automatic test_param_sweep();
    din1 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if ({dout1, rise1, fall1, busy1} !== {k >= 5, k == 5, 1'b0, k == 4}) begin
        errors++;
        $display("FAIL sweep_step edge %0d: got %b expected %b", k, {dout1, rise1, fall1, busy1},
                 {k >= 5, k == 5, 1'b0, k == 4});
      end
    end
    din1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      din1 = 1'b1;
      checks++;
      if ({dout1, rise1, fall1} !== 3'b100) begin
        errors++;
        $display("FAIL sweep_glitch edge %0d: dout/rise/fall got %b expected 100", k, {dout1, rise1, fall1});
      end
      checks++;
      if ({dout1, rise1, fall1, busy1} !== exp1()) begin
        errors++;
        $display("FAIL sweep_model edge %0d: got %b expected %b", k, {dout1, rise1, fall1, busy1}, exp1());
      end
    end
  endtask

  task automatic test_random();
    int hold0 = 0;
    int hold1 = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      checks++;
      if ({dout0, rise0, fall0, busy0} !== exp0()) begin
        errors++;
        $display("FAIL random_dut0 cycle %0d: got %b expected %b", k, {dout0, rise0, fall0, busy0}, exp0());
      end
      checks++;
      if ({dout1, rise1, fall1, busy1} !== exp1()) begin
        errors++;
        $display("FAIL random_dut1 cycle %0d: got %b expected %b", k, {dout1, rise1, fall1, busy1}, exp1());
      end
      if (hold0 == 0) begin
        din0  = $urandom_range(0, 1);
        hold0 = $urandom_range(1, 7);
      end else begin
        hold0--;
      end
      if (hold1 == 0) begin
        din1  = $urandom_range(0, 1);
        hold1 = $urandom_range(1, 4);
      end else begin
        hold1--;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_bounce();
    test_reset_mid_wait();
    test_param_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
